seq_factorial: RTL and testbench
================================

// Module: seq_factorial
// PURPOSE
//   Parametrised, clocked, iterative successor to the combinational N-bit factorial block.
//   Computes number! with one multiply per clock, using a start/busy/done handshake.
//   Configurable result width; a sticky overflow flag is raised when the result does not fit.
//   Sits as a compute engine behind a controller that issues start and waits for done.
// PARAMETERS
//   N      4   width of the operand number (0 .. 2^N-1)
//   OUT_W  64  width of the factorial result
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   start      in   1      request; sampled only in IDLE
//   number     in   N      operand, captured on the accepted start
//   busy       out  1      high while in CALC
//   done       out  1      one-cycle pulse when factorial/overflow are updated
//   factorial  out  OUT_W  result; held until the next completion
//   overflow   out  1      result exceeded OUT_W bits; held with factorial
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE. busy, done, factorial, overflow and internal acc/cnt/ovf all 0.
//     Asserting rst mid-calculation aborts the calculation. No done pulse is produced.
//   FSM states: IDLE, CALC. Internal registers: acc[OUT_W-1:0], cnt[N-1:0], ovf.
//   IDLE:
//     start=1 -> acc<=1, cnt<=number, ovf<=0, state<=CALC.
//     start=0 -> stay in IDLE.
//   CALC (busy=1):
//     cnt<=1 -> factorial<=acc, overflow<=ovf, done<=1, state<=IDLE.
//     otherwise:
//       p = acc*cnt, computed (OUT_W+N) bits wide.
//       If p[OUT_W+N-1:OUT_W]!=0, or ovf is already set:
//         ovf<=1 and acc<={OUT_W{1'b1}} (saturate).
//       Else acc<=p[OUT_W-1:0].
//       cnt<=cnt-1.
//   done is a registered pulse, high exactly one cycle.
//   busy is registered; it is 1 from the cycle after the accepted start through the final CALC cycle.
//   Latency from the edge accepting start to the edge asserting done: max(number,1) cycles.
//     0 and 1 take 1 cycle. number=n>=2 takes n cycles: n-1 multiplies plus 1 finishing cycle.
//   0! = 1! = 1. Both take the cnt<=1 path immediately.
//   start while busy: ignored. number changes during CALC: ignored, because the operand is captured.
//   start in the cycle done is high: accepted, since the state is IDLE.
//     factorial/overflow keep the old result until the new completion.
//   On overflow: factorial = all ones, overflow=1. Both are held until the next completion.
//   Multiplier is combinational inside CALC. No multicycle path is assumed.
// TESTING
//   1 Reset: rst pulse asynchronously, no clock edge -> busy=0, done=0, factorial=0, overflow=0.
//   2 Defaults, number=0,1,2,4,5,8,9,10 each with a start pulse:
//       factorial = 1,1,2,24,120,40320,362880,3628800. overflow=0.
//       done comes max(n,1) cycles after the accepted start.
//   3 number=15 -> factorial=1307674368000, overflow=0, latency 15 cycles.
//       busy is high for exactly 15 cycles.
//   4 OUT_W=16:
//       number=8 -> 40320, overflow=0.
//       number=9 -> factorial=16'hFFFF, overflow=1.
//       Then number=3 -> 6, overflow=0, so the sticky flag clears on the new run.
//   5 Handshake:
//       start held high through a number=5 run; number changed to 9 mid-run -> result 120, single done pulse.
//       Back-to-back start in the done cycle with number=4 -> next done gives 24.
//   6 rst asserted on cycle 3 of a number=10 run -> immediate IDLE, outputs 0, no done.
//       A following start with number=6 -> 720.

Source files
------------

// File: rtl/seq_factorial.sv
// Iterative factorial engine: one multiply per clock behind a start/busy/done handshake.
// The result saturates to all ones and raises a sticky overflow flag when it exceeds OUT_W bits.
module seq_factorial #(
    parameter int unsigned N     = 4,
    parameter int unsigned OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     number,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] factorial,
    output logic             overflow
);

    localparam int unsigned PW = OUT_W + N;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t            state;
    logic [OUT_W-1:0]  acc;
    logic [N-1:0]      cnt;
    logic              ovf;

    logic [PW-1:0]     prod_c;
    logic              prod_hi_c;
    logic              last_c;

    // Full-width product so that bits above OUT_W reveal an overflow
    assign prod_c    = PW'(acc) * PW'(cnt);
    assign prod_hi_c = |prod_c[PW-1:OUT_W];
    assign last_c    = (cnt <= N'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            factorial <= '0;
            overflow  <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= OUT_W'(1);
                        cnt   <= number;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (last_c) begin
                        factorial <= acc;
                        overflow  <= ovf;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        // Once saturated, stay saturated for the rest of the run
                        if (prod_hi_c || ovf) begin
                            ovf <= 1'b1;
                            acc <= {OUT_W{1'b1}};
                        end else begin
                            acc <= prod_c[OUT_W-1:0];
                        end
                        cnt <= cnt - N'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_factorial.sv
// Scoreboard bench for seq_factorial: a 64-bit and a 16-bit instance share clock and reset.
module tb_seq_factorial;

    typedef struct {
        logic [63:0] fact;
        logic        ovf;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  number = '0;
    logic        busy, done, overflow;
    logic [63:0] factorial;
    logic        start16 = 1'b0;
    logic [3:0]  number16 = '0;
    logic        busy16, done16, overflow16;
    logic [15:0] factorial16;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t q64[$];
    exp_t q16[$];
    logic prev_done   = 1'b0;
    logic prev_done16 = 1'b0;

    seq_factorial #(.N(4), .OUT_W(64)) dut (
        .clk(clk), .rst(rst), .start(start), .number(number),
        .busy(busy), .done(done), .factorial(factorial), .overflow(overflow)
    );

    seq_factorial #(.N(4), .OUT_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .number(number16),
        .busy(busy16), .done(done16), .factorial(factorial16), .overflow(overflow16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the 64-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (prev_done === 1'b1) check("done_pulse_width64", 64'(2), 64'(1));
            if (q64.size() == 0) begin
                check("unexpected_done64", 64'(1), 64'(0));
            end else begin
                e = q64.pop_front();
                check("factorial64", factorial, e.fact);
                check("overflow64", 64'(overflow), 64'(e.ovf));
                check("latency64", 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
        prev_done = done;
    end

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (done16 === 1'b1) begin
            if (prev_done16 === 1'b1) check("done_pulse_width16", 64'(2), 64'(1));
            if (q16.size() == 0) begin
                check("unexpected_done16", 64'(1), 64'(0));
            end else begin
                e = q16.pop_front();
                check("factorial16", 64'(factorial16), e.fact);
                check("overflow16", 64'(overflow16), 64'(e.ovf));
                check("latency16", 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
        prev_done16 = done16;
    end

    // Issue one start, push the expectation, wait for done and check busy length
    task automatic run(input bit sel16, input int n, input logic [63:0] f, input logic o);
        exp_t e;
        int   bcnt;
        int   lat;
        bit   seen;
        lat = (n < 1) ? 1 : n;
        @(negedge clk);
        if (sel16) begin start16 = 1'b1; number16 = 4'(n); end
        else       begin start   = 1'b1; number   = 4'(n); end
        @(posedge clk);
        #1;
        e.fact = f; e.ovf = o; e.acc_cyc = cyc; e.lat = lat;
        if (sel16) q16.push_back(e); else q64.push_back(e);
        start = 1'b0; start16 = 1'b0;
        bcnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((sel16 ? busy16 : busy) === 1'b1) bcnt++;
            if ((sel16 ? done16 : done) === 1'b1) seen = 1'b1;
        end
        check("done_timeout", 64'(seen), 64'(1));
        check("busy_cycles", 64'(bcnt), 64'(lat));
    endtask

    initial begin
        exp_t e;
        int   dcnt;
        bit   seen;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_factorial", factorial, 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(0, 0,  64'd1,       1'b0);
        run(0, 1,  64'd1,       1'b0);
        run(0, 2,  64'd2,       1'b0);
        run(0, 4,  64'd24,      1'b0);
        run(0, 5,  64'd120,     1'b0);
        run(0, 8,  64'd40320,   1'b0);
        run(0, 9,  64'd362880,  1'b0);
        run(0, 10, 64'd3628800, 1'b0);
        run(0, 15, 64'd1307674368000, 1'b0);

        run(1, 8, 64'd40320,  1'b0);
        run(1, 9, 64'hFFFF,   1'b1);
        run(1, 3, 64'd6,      1'b0);

        // start held high, operand changed mid-run, then re-accepted in the done cycle
        @(negedge clk);
        start = 1'b1; number = 4'd5;
        @(posedge clk);
        #1;
        e.fact = 64'd120; e.ovf = 1'b0; e.acc_cyc = cyc; e.lat = 5;
        q64.push_back(e);
        @(negedge clk);
        @(negedge clk);
        number = 4'd9;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("hold_done_timeout", 64'(seen), 64'(1));
        number = 4'd4;
        e.fact = 64'd24; e.ovf = 1'b0; e.acc_cyc = cyc + 1; e.lat = 4;
        q64.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted_busy", 64'(busy), 64'(1));
        check("b2b_old_result_held", factorial, 64'd120);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("b2b_done_timeout", 64'(seen), 64'(1));

        // Reset mid-run aborts with no done
        @(negedge clk);
        start = 1'b1; number = 4'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_factorial", factorial, 64'(0));
        check("abort_overflow", 64'(overflow), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'(0));
        run(0, 6, 64'd720, 1'b0);

        repeat (3) @(negedge clk);
        check("queue64_empty", 64'(q64.size()), 64'(0));
        check("queue16_empty", 64'(q16.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
